// File: rtl/fruit_tmpl_sad.sv
// -----------------------------------------------------------------------------
// fruit_tmpl_sad
//
// Template-matching stage placed directly after a fruit template ROM
// (2^ADDR_WIDTH x DATA_WIDTH, synchronous read, one-cycle latency). It drives
// the ROM address in lock-step with a downsampled feature stream, accumulates
// the sum of absolute differences (SAD) between feature and template, and at
// the end of the template emits a registered score plus a match flag.
//
// Optional build macro:
//   TMPL_DIFF_CLIP_EN  - when defined, each per-sample difference saturates at
//                        DIFF_CLIP before accumulation. Ports and latency are
//                        identical in both builds.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle pulse, begins a match run (honoured in IDLE only)
//   feat_data    in   [DATA_WIDTH]  feature sample
//   feat_valid   in   feat_data valid this cycle (no backpressure)
//   thresh       in   [SCORE_WIDTH] match threshold, sampled in DRAIN
//   rom_addr     out  [ADDR_WIDTH]  template ROM address (registered)
//   rom_data     in   [DATA_WIDTH]  ROM read data, one cycle after rom_addr
//   busy         out  high in RUN and DRAIN
//   score        out  [SCORE_WIDTH] final SAD, held until the next DONE
//   score_valid  out  one-cycle pulse in DONE
//   match        out  score <= thresh, updated together with score
// -----------------------------------------------------------------------------
module fruit_tmpl_sad #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 8,
  parameter int SCORE_WIDTH = 19,
  parameter int DIFF_CLIP   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  feat_data,
  input  logic                   feat_valid,
  input  logic [SCORE_WIDTH-1:0] thresh,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic                   busy,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   score_valid,
  output logic                   match
);

  // Elaboration-time sanity checks on the parameter set.
  if (DIFF_CLIP < 0) begin : g_bad_clip
    $error("fruit_tmpl_sad: DIFF_CLIP must be non-negative");
  end
  if (SCORE_WIDTH < ADDR_WIDTH + DATA_WIDTH) begin : g_bad_score_width
    $error("fruit_tmpl_sad: SCORE_WIDTH too small to hold N * (2^DATA_WIDTH - 1)");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ADDR_WIDTH-1:0]  r_idx;
  logic [DATA_WIDTH-1:0]  r_feat_q;
  logic                   r_pend;
  logic [SCORE_WIDTH-1:0] r_acc;
  logic [SCORE_WIDTH-1:0] r_score;
  logic                   r_match;

  logic                   w_accept;
  logic                   w_last;
  logic [DATA_WIDTH-1:0]  w_abs_diff;
  logic [DATA_WIDTH-1:0]  w_diff;
  logic [SCORE_WIDTH-1:0] w_sum;

  // A feature is only taken while RUN; IDLE/DRAIN/DONE ignore feat_valid.
  assign w_accept = (r_state == S_RUN) && feat_valid;
  assign w_last   = w_accept && (r_idx == LAST_IDX);

  // Compare first so the subtraction never wraps; result fits in DATA_WIDTH.
  assign w_abs_diff = (r_feat_q >= rom_data) ? (r_feat_q - rom_data)
                                             : (rom_data - r_feat_q);

`ifdef TMPL_DIFF_CLIP_EN
  // Saturate outliers (e.g. specular highlights). A ceiling above the sample
  // range never triggers, so the int compare avoids truncating DIFF_CLIP.
  assign w_diff = (int'(w_abs_diff) > DIFF_CLIP) ? DATA_WIDTH'(DIFF_CLIP)
                                                 : w_abs_diff;
`else
  assign w_diff = w_abs_diff;
`endif

  // rom_data pairs with feat_q only in the cycle after acceptance (pend set).
  assign w_sum = r_acc + (r_pend ? SCORE_WIDTH'(w_diff) : '0);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_feat_q <= '0;
      r_pend   <= 1'b0;
      r_acc    <= '0;
      r_score  <= '0;
      r_match  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx  <= '0;
            r_acc  <= '0;
            r_pend <= 1'b0;
          end
        end
        S_RUN: begin
          r_pend <= w_accept;
          r_acc  <= w_sum;
          if (w_accept) begin
            r_feat_q <= feat_data;
            // Natural wrap to 0 after the last template index.
            r_idx    <= r_idx + 1'b1;
          end
        end
        S_DRAIN: begin
          // Fold in the final pending difference and publish the result.
          r_acc   <= w_sum;
          r_pend  <= 1'b0;
          r_score <= w_sum;
          r_match <= (w_sum <= thresh);
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign rom_addr    = r_idx;
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign score_valid = (r_state == S_DONE);
  assign score       = r_score;
  assign match       = r_match;

endmodule

// File: tb/tb_fruit_tmpl_sad.sv
// -----------------------------------------------------------------------------
// tb_fruit_tmpl_sad
//
// Self-checking bench for fruit_tmpl_sad. A behavioural ROM returns
// template[i] = i[7:0] one cycle after the address. Expected scores come from
// a whole-template SAD computed directly over the feature array.
// Build with +define+TMPL_DIFF_CLIP_EN to check the clipped variant.
// -----------------------------------------------------------------------------
module tb_fruit_tmpl_sad;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int SW = 19;
  localparam int N  = 1 << AW;

`ifdef TMPL_DIFF_CLIP_EN
  localparam int ZERO_SCORE = 114432;
`else
  localparam int ZERO_SCORE = 261120;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] feat_data;
  logic          feat_valid;
  logic [SW-1:0] thresh;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          busy;
  logic [SW-1:0] score;
  logic          score_valid;
  logic          match;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] feat [N];

  always #5 clk = ~clk;

  // Template ROM: synchronous read, one-cycle latency.
  always @(posedge clk) rom_data <= rom_addr[DW-1:0];

  fruit_tmpl_sad dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .feat_data   (feat_data),
    .feat_valid  (feat_valid),
    .thresh      (thresh),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .busy        (busy),
    .score       (score),
    .score_valid (score_valid),
    .match       (match)
  );

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // pattern: 0 = all zero, 1 = identity (i[7:0]), 2 = random
  task automatic fill(input int pattern);
    for (int i = 0; i < N; i++) begin
      case (pattern)
        0:       feat[i] = '0;
        1:       feat[i] = DW'(i % 256);
        default: feat[i] = DW'($urandom_range(0, 255));
      endcase
    end
  endtask

  function automatic int ref_sad();
    int s;
    int d;
    s = 0;
    for (int i = 0; i < N; i++) begin
      d = int'(feat[i]) - (i % 256);
      if (d < 0) d = -d;
`ifdef TMPL_DIFF_CLIP_EN
      if (d > 64) d = 64;
`endif
      s += d;
    end
    return s;
  endfunction

  // Drives one complete run starting at the current negedge (DUT in IDLE).
  // gap_mode: 0 contiguous, 1 a gap before every sample after the first,
  // 2 random gaps. Returns score/match seen with score_valid, the number of
  // negedges from the last feature to score_valid (-1 if never), and a count
  // of address/busy/pulse protocol violations.
  task automatic run_once(input int gap_mode, input logic [SW-1:0] th,
                          input bit extra_start, input bit start_with_valid,
                          output logic [SW-1:0] sc, output logic m,
                          output int lat, output int errs);
    bit gap;
    errs = 0;
    sc   = '0;
    m    = 1'b0;
    thresh     = th;
    start      = 1'b1;
    feat_valid = start_with_valid;
    feat_data  = 8'hA5;
    @(negedge clk);
    start      = 1'b0;
    feat_valid = 1'b0;
    if (busy !== 1'b1) errs++;
    for (int i = 0; i < N; i++) begin
      gap = (gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0);
      if (gap) begin
        feat_valid = 1'b0;
        @(negedge clk);
        if (busy !== 1'b1) errs++;
      end
      feat_valid = 1'b1;
      feat_data  = feat[i];
      if (rom_addr !== AW'(i)) errs++;
      if (busy !== 1'b1) errs++;
      if (extra_start && i == 500) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    feat_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      if (score_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (k == 1 && busy !== 1'b1) errs++;
      @(negedge clk);
    end
    if (lat > 0) begin
      sc = score;
      m  = match;
      if (busy !== 1'b0) errs++;
      @(negedge clk);
      if (score_valid !== 1'b0 || score !== sc) errs++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; feat_valid = 1'b0; feat_data = '0; thresh = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (score_valid !== 1'b0) begin n_fail++; $display("FAIL reset_score_valid: got %b expected 0", score_valid); end
    n_tests++; if (score !== '0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b expected 0", match); end
    n_tests++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exact_match();
    logic [SW-1:0] sc; logic m; int lat, errs;
    fill(1);
    run_once(0, '0, 1'b0, 1'b0, sc, m, lat, errs);
    n_tests++; if (sc !== '0) begin n_fail++; $display("FAIL exact_score: got %0d expected 0", sc); end
    n_tests++; if (m !== 1'b1) begin n_fail++; $display("FAIL exact_match: got %b expected 1", m); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL exact_latency: got %0d expected 2", lat); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL exact_protocol: got %0d violations expected 0", errs); end
  endtask

  task automatic test_zero_features();
    logic [SW-1:0] sc; logic m; int lat, errs;
    fill(0);
    run_once(0, SW'(261119), 1'b0, 1'b0, sc, m, lat, errs);
    n_tests++; if (sc !== SW'(ZERO_SCORE)) begin n_fail++; $display("FAIL zero_score: got %0d expected %0d", sc, ZERO_SCORE); end
    n_tests++; if (m !== (ZERO_SCORE <= 261119)) begin n_fail++; $display("FAIL zero_match_261119: got %b expected %b", m, ZERO_SCORE <= 261119); end
    n_tests++; if (errs != 0 || lat != 2) begin n_fail++; $display("FAIL zero_protocol: got %0d violations latency %0d expected 0 and 2", errs, lat); end
    run_once(0, SW'(261120), 1'b0, 1'b0, sc, m, lat, errs);
    n_tests++; if (sc !== SW'(ZERO_SCORE)) begin n_fail++; $display("FAIL zero_score_rerun: got %0d expected %0d", sc, ZERO_SCORE); end
    n_tests++; if (m !== 1'b1) begin n_fail++; $display("FAIL zero_match_261120: got %b expected 1", m); end
  endtask

  task automatic test_valid_gaps();
    logic [SW-1:0] sc; logic m; int lat, errs; logic [SW-1:0] th;
    fill(0);
    th = SW'($urandom_range(100000, 300000));
    run_once(1, th, 1'b0, 1'b0, sc, m, lat, errs);
    n_tests++; if (sc !== SW'(ZERO_SCORE)) begin n_fail++; $display("FAIL gaps_score: got %0d expected %0d", sc, ZERO_SCORE); end
    n_tests++; if (m !== (ZERO_SCORE <= int'(th))) begin n_fail++; $display("FAIL gaps_match: got %b expected %b", m, ZERO_SCORE <= int'(th)); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL gaps_protocol: got %0d violations expected 0", errs); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL gaps_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_start_handling();
    logic [SW-1:0] sc; logic m; int lat, errs; int exp_sc;
    fill(2);
    exp_sc = ref_sad();
    run_once(0, SW'(exp_sc), 1'b1, 1'b1, sc, m, lat, errs);
    n_tests++; if (sc !== SW'(exp_sc)) begin n_fail++; $display("FAIL start_score: got %0d expected %0d", sc, exp_sc); end
    n_tests++; if (m !== 1'b1) begin n_fail++; $display("FAIL start_match: got %b expected 1", m); end
    n_tests++; if (errs != 0 || lat != 2) begin n_fail++; $display("FAIL start_protocol: got %0d violations latency %0d expected 0 and 2", errs, lat); end
  endtask

  task automatic test_random();
    logic [SW-1:0] sc; logic m; int lat, errs; int exp_sc; int th;
    for (int r = 0; r < 4; r++) begin
      fill(2);
      exp_sc = ref_sad();
      if (r == 3) th = int'($urandom_range(0, (1 << SW) - 1));
      else        th = exp_sc + int'($urandom_range(0, 4)) - 2;
      run_once(2, SW'(th), 1'b0, 1'b0, sc, m, lat, errs);
      n_tests++; if (sc !== SW'(exp_sc)) begin n_fail++; $display("FAIL random%0d_score: got %0d expected %0d", r, sc, exp_sc); end
      n_tests++; if (m !== (exp_sc <= th)) begin n_fail++; $display("FAIL random%0d_match: got %b expected %b (thresh %0d)", r, m, exp_sc <= th, th); end
      n_tests++; if (errs != 0 || lat != 2) begin n_fail++; $display("FAIL random%0d_protocol: got %0d violations latency %0d expected 0 and 2", r, errs, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] sc; logic m; int lat, errs; int exp_sc;
    for (int r = 0; r < 2; r++) begin
      fill(2);
      exp_sc = ref_sad();
      run_once(0, SW'(exp_sc - 1), 1'b0, 1'b0, sc, m, lat, errs);
      n_tests++; if (sc !== SW'(exp_sc)) begin n_fail++; $display("FAIL b2b%0d_score: got %0d expected %0d", r, sc, exp_sc); end
      n_tests++; if (m !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_match: got %b expected 0", r, m); end
      n_tests++; if (errs != 0 || lat != 2) begin n_fail++; $display("FAIL b2b%0d_protocol: got %0d violations latency %0d expected 0 and 2", r, errs, lat); end
    end
  endtask

  task automatic test_reset_midrun();
    logic [SW-1:0] sc; logic m; int lat, errs; int sv_seen;
    fill(2);
    thresh = '1; start = 1'b1; feat_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      feat_valid = 1'b1;
      feat_data  = feat[i];
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_tests++; if (score !== '0 || match !== 1'b0 || score_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got score %0d match %b score_valid %b expected all 0", score, match, score_valid); end
    n_tests++; if (rom_addr !== '0) begin n_fail++; $display("FAIL midrst_rom_addr: got %0d expected 0", rom_addr); end
    @(negedge clk);
    feat_valid = 1'b0;
    rst = 1'b0;
    sv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (score_valid !== 1'b0 || busy !== 1'b0) sv_seen++;
    end
    n_tests++; if (sv_seen != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", sv_seen); end
    fill(0);
    run_once(0, SW'(261120), 1'b0, 1'b0, sc, m, lat, errs);
    n_tests++; if (sc !== SW'(ZERO_SCORE)) begin n_fail++; $display("FAIL midrst_rerun_score: got %0d expected %0d", sc, ZERO_SCORE); end
    n_tests++; if (errs != 0 || lat != 2) begin n_fail++; $display("FAIL midrst_rerun_protocol: got %0d violations latency %0d expected 0 and 2", errs, lat); end
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_zero_features();
    test_valid_gaps();
    test_start_handling();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
